data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
// - Responder end of the CPU data SRAM interface: serves the core's en/we/addr/wdata requests, returns rdata.
// - Contains a byte-writable RAM plus a small MMIO register window (LED, switches, scratch, optional timer).
// - Sits beside the CPU top in the SoC wrapper, wired directly to the MEM stage's data_sram_* ports.
// PARAMETERS
// - ADDR_WIDTH  14            word-index bits of RAM (2^14 words = 64 KB)
// - MMIO_BASE   32'hBFAF_0000 base of MMIO window; decoded on addr[31:16]
// PORTS
// - clk              in   1   single system clock, all state on posedge
// - reset            in   1   synchronous, active-high reset
// - data_sram_en     in   1   access request this cycle
// - data_sram_we     in   4   byte write enables; 4'h0 = read
// - data_sram_addr   in   32  byte address; addr[1:0] ignored (word access)
// - data_sram_wdata  in   32  write data, lane i = wdata[8i+7:8i]
// - data_sram_rdata  out  32  read data, registered
// - led              out  16  LED register contents
// - switch_in        in   8   board switches, sampled on read
// BEHAVIOUR
// - Reset (reset=1 at posedge): rdata=0, led=0, scratch0/1=0, timer=0, timer_ctrl=0; RAM contents not cleared.
// - Access sampled in reset cycle is discarded (no write, no rdata update).
// - Decode: addr[31:16]==MMIO_BASE[31:16] -> MMIO; else RAM at index addr[ADDR_WIDTH+1:2]; upper bits ignored (aliasing).
// - Read: en=1, we=0 at edge N -> rdata valid from edge N until next read edge; fixed 1-cycle latency, no stall.
// - Write: en=1, we!=0 -> only lanes with we[i]=1 updated at the edge; rdata NOT updated by writes (holds).
// - en=0: no RAM/register change, rdata holds; timer still counts.
// - Write at edge N then read same address at edge N+1 -> rdata shows written bytes merged with old bytes.
// - MMIO map (offset from MMIO_BASE, word aligned):
//   0x00 LED        R/W, bits[15:0], lane enables apply; bits[31:16] read 0
//   0x04 SWITCH     RO, {24'b0, switch_in}; writes ignored
//   0x08 SCRATCH0   R/W 32-bit, lane enables apply
//   0x0C SCRATCH1   R/W 32-bit, lane enables apply
//   0x10 TIMER      R/W 32-bit counter (see CONFIGURATION)
//   0x14 TIMER_CTRL R/W bit0 = count enable; other bits read 0
//   other offsets   read 0, writes ignored
// - Timer: +1 every cycle while ctrl[0]=1; wraps 32'hFFFF_FFFF -> 0.
// - Timer write and increment on same edge: written (lane-merged) value wins, no increment that cycle.
// - Timer read at edge N returns value held before edge N.
// - No X propagation: rdata never depends on uninitialised MMIO state.
// CONFIGURATION
// - Macro DSRAM_RSP_TIMER_EN.
// - Defined: TIMER (0x10) and TIMER_CTRL (0x14) implemented as above.
// - Undefined: no counter logic; 0x10/0x14 behave as unmapped (read 0, writes ignored).
// TESTING
// - Reset, then read RAM 0x0000_0100 and MMIO 0x00 -> rdata=0 for LED read; led=0 during and after reset.
// - Write 0x1234_5678 we=4'hF to 0x40, then we=4'h2 wdata=0x0000_AB00, read 0x40 -> 0x1234_AB78 one cycle later.
// - switch_in=8'hA5, read MMIO_BASE+0x04 -> 0x0000_00A5; write there, re-read -> still 0x0000_00A5.
// - Write LED 0xFFFF_BEEF we=4'hF -> led=16'hBEEF, read -> 0x0000_BEEF; read MMIO_BASE+0x20 -> 0.
// - TIMER_EN: write TIMER=0xFFFF_FFFE, ctrl=1, wait 3 cycles, read -> 0x0000_0001 (wrap); write TIMER=5 with ctrl=1 -> next value 5, then 6.
// - Assert reset mid-stream during a write to 0x80 -> word at 0x80 unchanged, rdata=0 next cycle.

Source files
------------

// File: rtl/data_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder_if
// Brief    : CPU data SRAM request/response bundle. The master (core MEM
//            stage) drives en/we/addr/wdata; the slave (responder) returns
//            the registered rdata.
// Revision : 1.0 - initial release
// ============================================================================
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_we,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_we,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder
// Brief    : Responder end of the CPU data SRAM port. Byte-writable RAM of
//            2^ADDR_WIDTH words plus an MMIO window (LED, switches, two
//            scratch registers, optional free-running timer). Reads have a
//            fixed one-cycle latency; writes never disturb rdata.
//            Optional feature macro: DSRAM_RSP_TIMER_EN (TIMER/TIMER_CTRL).
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  data_sram_responder_if.slave        bus,
  output logic [15:0]                 led,
  input  logic [7:0]                  switch_in
);

  localparam int RAM_WORDS = 2 ** ADDR_WIDTH;

  // MMIO register word indices (byte offset >> 2)
  localparam logic [13:0] OFS_LED        = 14'h0000;
  localparam logic [13:0] OFS_SWITCH     = 14'h0001;
  localparam logic [13:0] OFS_SCRATCH0   = 14'h0002;
  localparam logic [13:0] OFS_SCRATCH1   = 14'h0003;
  localparam logic [13:0] OFS_TIMER      = 14'h0004;
  localparam logic [13:0] OFS_TIMER_CTRL = 14'h0005;

  // --------------------------------------------------------------------------
  // Request decode. Any access presented while reset is high is dropped.
  // --------------------------------------------------------------------------
  logic                  is_mmio;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [13:0]           mmio_word;
  logic                  req_read;
  logic                  req_write;
  logic                  ram_wr;
  logic                  mmio_wr;
  logic                  unused_addr_lsb;

  assign is_mmio   = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_idx   = bus.data_sram_addr[ADDR_WIDTH+1:2];
  assign mmio_word = bus.data_sram_addr[15:2];
  assign req_read  = bus.data_sram_en && (bus.data_sram_we == 4'h0) && !reset;
  assign req_write = bus.data_sram_en && (bus.data_sram_we != 4'h0) && !reset;
  assign ram_wr    = req_write && !is_mmio;
  assign mmio_wr   = req_write &&  is_mmio;

  // Accesses are word granular; the byte offset bits carry no meaning.
  assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

  // Replace the byte lanes of old_word selected by lane_en with new_word's.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  // --------------------------------------------------------------------------
  // RAM array: no reset so it maps onto block RAM; byte lanes written
  // independently.
  // --------------------------------------------------------------------------
  logic [31:0] mem_q [RAM_WORDS];
  logic [31:0] ram_rdata;

  // Lane-masked RAM write
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_we[i]) begin
          mem_q[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign ram_rdata = mem_q[ram_idx];

  // --------------------------------------------------------------------------
  // Optional timer. When compiled out, its offsets fall through to the
  // unmapped (read-zero, write-ignored) path.
  // --------------------------------------------------------------------------
  logic [31:0] timer_rdata;
  logic [31:0] timer_ctrl_rdata;

`ifdef DSRAM_RSP_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic        timer_en_q;
  logic        timer_en_d;

  // Timer next state: a software write takes priority over the increment
  always_comb begin
    timer_d    = timer_q;
    timer_en_d = timer_en_q;
    if (mmio_wr && (mmio_word == OFS_TIMER)) begin
      timer_d = lane_merge(timer_q, bus.data_sram_wdata, bus.data_sram_we);
    end else if (timer_en_q) begin
      timer_d = timer_q + 32'd1;
    end
    if (mmio_wr && (mmio_word == OFS_TIMER_CTRL) && bus.data_sram_we[0]) begin
      timer_en_d = bus.data_sram_wdata[0];
    end
  end

  // Timer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= 32'h0;
      timer_en_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      timer_en_q <= timer_en_d;
    end
  end

  assign timer_rdata      = timer_q;
  assign timer_ctrl_rdata = {31'h0, timer_en_q};
`else
  assign timer_rdata      = 32'h0;
  assign timer_ctrl_rdata = 32'h0;
`endif

  // --------------------------------------------------------------------------
  // Always-present MMIO registers and the read data register
  // --------------------------------------------------------------------------
  logic [15:0] led_q;
  logic [15:0] led_d;
  logic [31:0] scratch0_q;
  logic [31:0] scratch0_d;
  logic [31:0] scratch1_q;
  logic [31:0] scratch1_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic [31:0] mmio_rdata;

  // MMIO register write merge (LED only owns lanes 0 and 1)
  always_comb begin
    led_d      = led_q;
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    if (mmio_wr && (mmio_word == OFS_LED)) begin
      if (bus.data_sram_we[0]) led_d[7:0]  = bus.data_sram_wdata[7:0];
      if (bus.data_sram_we[1]) led_d[15:8] = bus.data_sram_wdata[15:8];
    end
    if (mmio_wr && (mmio_word == OFS_SCRATCH0)) begin
      scratch0_d = lane_merge(scratch0_q, bus.data_sram_wdata, bus.data_sram_we);
    end
    if (mmio_wr && (mmio_word == OFS_SCRATCH1)) begin
      scratch1_d = lane_merge(scratch1_q, bus.data_sram_wdata, bus.data_sram_we);
    end
  end

  // MMIO read mux and read-data capture; writes and idle cycles hold rdata
  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_word)
      OFS_LED:        mmio_rdata = {16'h0, led_q};
      OFS_SWITCH:     mmio_rdata = {24'h0, switch_in};
      OFS_SCRATCH0:   mmio_rdata = scratch0_q;
      OFS_SCRATCH1:   mmio_rdata = scratch1_q;
      OFS_TIMER:      mmio_rdata = timer_rdata;
      OFS_TIMER_CTRL: mmio_rdata = timer_ctrl_rdata;
      default:        mmio_rdata = 32'h0;
    endcase
    rdata_d = rdata_q;
    if (req_read) begin
      rdata_d = is_mmio ? mmio_rdata : ram_rdata;
    end
  end

  // Register state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= 16'h0;
      scratch0_q <= 32'h0;
      scratch1_q <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      led_q      <= led_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign led                 = led_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_responder
// Brief    : Randomised scoreboard bench for data_sram_responder. A driver
//            issues one request per cycle and pushes the expected rdata/led
//            computed by a behavioural memory-map model; an independent
//            monitor pops and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

  localparam logic [31:0] MMIO = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] led;
  logic [7:0]  switch_in;

  data_sram_responder_if bus();

  data_sram_responder #(
    .ADDR_WIDTH (14),
    .MMIO_BASE  (MMIO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .led       (led),
    .switch_in (switch_in)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    bit          rd_known;
    logic [31:0] rd;
    logic [15:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: the memory map as plain variables
  // --------------------------------------------------------------------------
  bit [31:0] m_ram   [int];
  bit [3:0]  m_known [int];
  bit [31:0] m_rd;
  bit        m_rd_ok;
  bit [15:0] m_led;
  bit [31:0] m_s0, m_s1, m_tmr;
  bit        m_ctl;

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] we);
    bit [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic bit [31:0] mmio_val(input int w, input bit [7:0] sw);
    case (w)
      0: return {16'h0, m_led};
      1: return {24'h0, sw};
      2: return m_s0;
      3: return m_s1;
`ifdef DSRAM_RSP_TIMER_EN
      4: return m_tmr;
      5: return {31'h0, m_ctl};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit [3:0] we,
                            input bit [31:0] a, input bit [31:0] wd, input bit [7:0] sw);
    bit mmio;
    int w;
    int key;
    bit old_ctl;
    bit tmr_written;
    mmio = (a[31:16] == MMIO[31:16]);
    w    = int'(a[15:2]);
    key  = int'(a[15:2]);
    old_ctl = m_ctl;
    tmr_written = 1'b0;
    if (rst) begin
      m_rd = 0; m_rd_ok = 1; m_led = 0; m_s0 = 0; m_s1 = 0; m_tmr = 0; m_ctl = 0;
      return;
    end
    if (en && we == 4'h0) begin
      if (mmio) begin
        m_rd = mmio_val(w, sw);
        m_rd_ok = 1;
      end else begin
        m_rd_ok = m_known.exists(key) && (m_known[key] == 4'hF);
        m_rd = m_rd_ok ? m_ram[key] : 32'h0;
      end
    end else if (en) begin
      if (mmio) begin
        case (w)
          0: begin bit [31:0] t; t = merge({16'h0, m_led}, wd, we); m_led = t[15:0]; end
          2: m_s0 = merge(m_s0, wd, we);
          3: m_s1 = merge(m_s1, wd, we);
`ifdef DSRAM_RSP_TIMER_EN
          4: begin m_tmr = merge(m_tmr, wd, we); tmr_written = 1'b1; end
          5: if (we[0]) m_ctl = wd[0];
`endif
          default: ;
        endcase
      end else begin
        m_ram[key]   = merge(m_ram.exists(key) ? m_ram[key] : 32'h0, wd, we);
        m_known[key] = (m_known.exists(key) ? m_known[key] : 4'h0) | we;
      end
    end
`ifdef DSRAM_RSP_TIMER_EN
    if (!tmr_written && old_ctl) m_tmr = m_tmr + 1;
`else
    if (tmr_written || old_ctl) m_tmr = m_tmr;
`endif
  endtask

  // Drive one request on the falling edge and record what the next rising
  // edge must produce.
  task automatic cyc(input bit rst, input bit en, input bit [3:0] we,
                     input bit [31:0] a, input bit [31:0] wd, input bit [7:0] sw);
    exp_t e;
    @(negedge clk);
    reset               = rst;
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = a;
    bus.data_sram_wdata = wd;
    switch_in           = sw;
    model_step(rst, en, we, a, wd, sw);
    e.rd_known = m_rd_ok;
    e.rd       = m_rd;
    e.led      = m_led;
    exp_q.push_back(e);
  endtask

  task automatic rd(input bit [31:0] a);
    cyc(0, 1, 4'h0, a, 32'h0, switch_in);
  endtask

  task automatic wr(input bit [31:0] a, input bit [31:0] wd, input bit [3:0] we);
    cyc(0, 1, we, a, wd, switch_in);
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 32'h0, 32'h0, switch_in);
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.rd_known) check("rdata", bus.data_sram_rdata, e.rd);
        check("led", {16'h0, led}, {16'h0, e.led});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  bit [15:0] ofs_tab [9] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010,
                             16'h0014, 16'h0018, 16'h0020, 16'hFFFC};

  initial begin
    reset = 1'b1;
    bus.data_sram_en = 1'b0;
    bus.data_sram_we = 4'h0;
    bus.data_sram_addr = 32'h0;
    bus.data_sram_wdata = 32'h0;
    switch_in = 8'h00;

    // Reset, with a read presented during reset that must be dropped
    cyc(1, 1, 4'h0, MMIO, 32'h0, 8'h00);
    cyc(1, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    rd(32'h0000_0100);
    rd(MMIO);

    // Byte-lane merge on RAM
    wr(32'h0000_0040, 32'h1234_5678, 4'hF);
    wr(32'h0000_0040, 32'h0000_AB00, 4'h2);
    rd(32'h0000_0040);
    idle();

    // Switch register is read-only
    switch_in = 8'hA5;
    rd(MMIO + 32'h4);
    wr(MMIO + 32'h4, 32'hFFFF_FFFF, 4'hF);
    rd(MMIO + 32'h4);

    // LED register and an unmapped offset
    wr(MMIO, 32'hFFFF_BEEF, 4'hF);
    rd(MMIO);
    rd(MMIO + 32'h20);

`ifdef DSRAM_RSP_TIMER_EN
    wr(MMIO + 32'h10, 32'hFFFF_FFFE, 4'hF);
    wr(MMIO + 32'h14, 32'h0000_0001, 4'hF);
    idle(); idle(); idle();
    rd(MMIO + 32'h10);
    wr(MMIO + 32'h10, 32'h0000_0005, 4'hF);
    rd(MMIO + 32'h10);
    rd(MMIO + 32'h10);
    rd(MMIO + 32'h14);
`else
    wr(MMIO + 32'h10, 32'h1234_5678, 4'hF);
    rd(MMIO + 32'h10);
    wr(MMIO + 32'h14, 32'h0000_0001, 4'hF);
    rd(MMIO + 32'h14);
`endif

    // Reset mid-stream during a write must leave RAM untouched
    wr(32'h0000_0080, 32'hCAFE_F00D, 4'hF);
    cyc(1, 1, 4'hF, 32'h0000_0080, 32'hDEAD_BEEF, switch_in);
    rd(32'h0000_0080);

    // Seed the random RAM working set
    for (int k = 0; k < 16; k++) wr(32'h0000_0040 + 32'(k * 4), $urandom, 4'hF);

    // Randomised traffic over RAM (with aliased upper bits) and MMIO
    for (int n = 0; n < 600; n++) begin
      bit        r_rst, r_en;
      bit [3:0]  r_we;
      bit [31:0] r_a;
      r_rst = ($urandom_range(0, 59) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        r_a = MMIO | {16'h0, ofs_tab[$urandom_range(0, 8)]} | 32'($urandom_range(0, 3));
      end else begin
        r_a[31:16] = 16'($urandom);
        if (r_a[31:16] == MMIO[31:16]) r_a[31:16] = 16'h0;
        r_a[15:0] = 16'h0040 + 16'($urandom_range(0, 16) * 4) + 16'($urandom_range(0, 3));
      end
      cyc(r_rst, r_en, r_we, r_a, $urandom, 8'($urandom));
    end

    idle();
    @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
